// File: rtl/conf_sched.sv
// rtl/conf_sched.sv - round-robin pulse scheduler with minimum output separation
// Queues per-channel pulse requests and releases them to a single merge point.
module conf_sched #(
  parameter int N_REQ      = 4,
  parameter int SEP_CYCLES = 3,
  parameter int CNT_W      = 3,
  parameter int SRC_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  input  logic             clr_ovf,
  output logic             out_pulse,
  output logic [SRC_W-1:0] out_src,
  output logic             pending_any,
  output logic [N_REQ-1:0] overflow
);

  localparam int SEP_W = (SEP_CYCLES > 1) ? $clog2(SEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SEP_W-1:0] SEP_LOAD = SEP_W'(SEP_CYCLES - 1);

  logic [N_REQ-1:0][CNT_W-1:0] r_cnt;
  logic [SEP_W-1:0]            r_sep;
  logic [SRC_W-1:0]            r_rr;
  logic                        r_pulse;
  logic [SRC_W-1:0]            r_src;
  logic                        r_pending;
  logic [N_REQ-1:0]            r_ovf;

  logic [N_REQ-1:0]            w_nz;
  logic                        w_found;
  logic [SRC_W-1:0]            w_win;
  logic [SRC_W-1:0]            w_idx;
  logic                        w_grant;
  logic [SRC_W-1:0]            w_rr_nxt;
  logic [N_REQ-1:0]            w_gnt_vec;
  logic [N_REQ-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [N_REQ-1:0]            w_ovf_set;
  logic                        w_pend_nxt;

  always_comb begin
    w_nz = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_nz[i] = (r_cnt[i] != '0);
    end
  end

  // Search starts at the round-robin pointer and wraps modulo N_REQ, not 2**SRC_W.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = SRC_W'((int'(r_rr) + k) % N_REQ);
      if (!w_found && w_nz[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_grant  = enable && (r_sep == '0) && w_found;
  assign w_rr_nxt = (w_win == SRC_W'(N_REQ - 1)) ? '0 : w_win + SRC_W'(1);

  always_comb begin
    w_gnt_vec  = '0;
    w_cnt_nxt  = r_cnt;
    w_ovf_set  = '0;
    w_pend_nxt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_gnt_vec[i] = w_grant && (w_win == SRC_W'(i));
      if (req[i] && !w_gnt_vec[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end else if (!req[i] && w_gnt_vec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
      end
      w_pend_nxt = w_pend_nxt | (w_cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sep     <= '0;
      r_rr      <= '0;
      r_pulse   <= 1'b0;
      r_src     <= '0;
      r_pending <= 1'b0;
      r_ovf     <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pend_nxt;
      r_pulse   <= w_grant;
      // A new overflow event wins over a simultaneous clear.
      r_ovf     <= w_ovf_set | (clr_ovf ? '0 : r_ovf);
      if (r_sep != '0) begin
        r_sep <= r_sep - SEP_W'(1);
      end else if (w_grant) begin
        r_sep <= SEP_LOAD;
      end
      if (w_grant) begin
        r_src <= w_win;
        r_rr  <= w_rr_nxt;
      end
    end
  end

  assign out_pulse   = r_pulse;
  assign out_src     = r_src;
  assign pending_any = r_pending;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_conf_sched.sv
// tb/tb_conf_sched.sv - randomized and directed bench for conf_sched against a reference model
module tb_conf_sched;

  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int SW   = 2;
  localparam int MAXC = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req = '0;
  logic          enable = 1'b0;
  logic          clr_ovf = 1'b0;

  logic          pulse_a, pulse_b;
  logic [SW-1:0] src_a, src_b;
  logic          pend_a, pend_b;
  logic [N-1:0]  ovf_a, ovf_b;

  always #5 clk = ~clk;

  conf_sched #(.N_REQ(N), .SEP_CYCLES(3), .CNT_W(CW), .SRC_W(SW)) u_dut_sep3 (
    .clk(clk), .rst_n(rst_n), .req(req), .enable(enable), .clr_ovf(clr_ovf),
    .out_pulse(pulse_a), .out_src(src_a), .pending_any(pend_a), .overflow(ovf_a)
  );

  conf_sched #(.N_REQ(N), .SEP_CYCLES(1), .CNT_W(CW), .SRC_W(SW)) u_dut_sep1 (
    .clk(clk), .rst_n(rst_n), .req(req), .enable(enable), .clr_ovf(clr_ovf),
    .out_pulse(pulse_b), .out_src(src_b), .pending_any(pend_b), .overflow(ovf_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue depths per channel, time of last grant, and rotating start index.
  int       m_cnt  [2][N];
  int       m_rr   [2];
  int       m_last [2];
  bit       m_pulse[2];
  int       m_src  [2];
  bit [N-1:0] m_ovf[2];
  int       edge_no = 0;

  function automatic int sep_of(input int m);
    return (m == 0) ? 3 : 1;
  endfunction

  function automatic bit model_pending(input int m);
    bit any = 1'b0;
    for (int i = 0; i < N; i++) if (m_cnt[m][i] > 0) any = 1'b1;
    return any;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) m_cnt[m][i] = 0;
      m_rr[m]    = 0;
      m_last[m]  = -1000;
      m_pulse[m] = 1'b0;
      m_src[m]   = 0;
      m_ovf[m]   = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int win = -1;
      bit [N-1:0] set = '0;
      if (enable && (edge_no - m_last[m] >= sep_of(m))) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && m_cnt[m][(m_rr[m] + k) % N] > 0) win = (m_rr[m] + k) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        bit inc = req[i];
        bit dec = (win == i);
        if (inc && !dec) begin
          if (m_cnt[m][i] == MAXC) set[i] = 1'b1;
          else m_cnt[m][i]++;
        end else if (dec && !inc) begin
          m_cnt[m][i]--;
        end
      end
      m_ovf[m]   = clr_ovf ? set : (m_ovf[m] | set);
      m_pulse[m] = (win >= 0);
      if (win >= 0) begin
        m_src[m]  = win;
        m_rr[m]   = (win + 1) % N;
        m_last[m] = edge_no;
      end
    end
    edge_no++;
  endtask

  task automatic check_outputs();
    check_val("pulse_sep3", 32'(pulse_a), 32'(m_pulse[0]));
    check_val("src_sep3",   32'(src_a),   32'(m_src[0]));
    check_val("pend_sep3",  32'(pend_a),  32'(model_pending(0)));
    check_val("ovf_sep3",   32'(ovf_a),   32'(m_ovf[0]));
    check_val("pulse_sep1", 32'(pulse_b), 32'(m_pulse[1]));
    check_val("src_sep1",   32'(src_b),   32'(m_src[1]));
    check_val("pend_sep1",  32'(pend_b),  32'(model_pending(1)));
    check_val("ovf_sep1",   32'(ovf_b),   32'(m_ovf[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_outputs();
  endtask

  // Called 1 time unit after an edge; asserts reset between edges and releases it mid-cycle.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single request on channel 2 into an idle block.
    enable = 1'b1;
    repeat (3) tick();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (8) tick();

    // All channels at once: round-robin order at the configured spacing.
    req = 4'b1111;
    tick();
    req = '0;
    repeat (16) tick();

    // Saturation with grants blocked, then overflow-set versus clear on channel 0.
    enable = 1'b0;
    req = 4'b0011;
    repeat (10) tick();
    req = 4'b0001;
    clr_ovf = 1'b1;
    tick();
    req = '0;
    tick();
    clr_ovf = 1'b0;
    enable = 1'b1;
    repeat (50) tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tick();

    // Reset while work is queued on channel 3, then idle.
    enable = 1'b0;
    req = 4'b1000;
    repeat (3) tick();
    req = '0;
    async_reset();
    enable = 1'b1;
    repeat (10) tick();

    // Continuous traffic on channels 0 and 1.
    req = 4'b0011;
    repeat (20) tick();
    req = '0;
    repeat (40) tick();

    // Randomized traffic, including a reset that can land on an in-flight pulse.
    for (int n = 0; n < 500; n++) begin
      req     = N'($urandom & $urandom);
      enable  = ($urandom_range(0, 7) != 0);
      clr_ovf = ($urandom_range(0, 24) == 0);
      if (n == 250) async_reset();
      tick();
    end
    req = '0;
    clr_ovf = 1'b0;
    enable = 1'b1;
    repeat (100) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
